// File: rtl/kv_txn_sequencer.sv
// Upstream command stage for the cuckoo-hash ledger store: buffers search/insert/transfer
// requests and expands each into timed store commands, returning one result per request.
module kv_txn_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 12,
  parameter int KEY_WIDTH     = 32,
  parameter int VAL_WIDTH     = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [KEY_WIDTH-1:0] in_src_key,
  input  logic [KEY_WIDTH-1:0] in_dst_key,
  input  logic [VAL_WIDTH-1:0] in_amount,
  output logic [KEY_WIDTH-1:0] kv_key,
  output logic [VAL_WIDTH-1:0] kv_value,
  output logic [1:0]           kv_signal,
  output logic [VAL_WIDTH-1:0] kv_transact_value,
  output logic                 kv_transact_kind,
  input  logic [VAL_WIDTH-1:0] kv_updated_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_status,
  output logic [VAL_WIDTH-1:0] out_src_balance,
  output logic [VAL_WIDTH-1:0] out_dst_balance,
  output logic                 busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] OP_INSERT    = 2'd1;
  localparam logic [1:0] OP_TRANSFER  = 2'd2;
  localparam logic [1:0] OP_ILLEGAL   = 2'd3;
  localparam logic [1:0] SIG_SEARCH   = 2'd0;
  localparam logic [1:0] SIG_INSERT   = 2'd1;
  localparam logic [1:0] SIG_TRANSACT = 2'd2;
  localparam logic [1:0] STAT_OK      = 2'd0;
  localparam logic [1:0] STAT_INSUF   = 2'd1;
  localparam logic [1:0] STAT_BAD     = 2'd2;

  typedef struct packed {
    logic [1:0]           op;
    logic [KEY_WIDTH-1:0] src;
    logic [KEY_WIDTH-1:0] dst;
    logic [VAL_WIDTH-1:0] amount;
  } req_t;

  typedef enum logic [2:0] {IDLE, POP, CHECK, DEBIT, CREDIT, INSERT, GAP, RESP} state_t;

  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_count;
  logic             push, pop, fifo_empty;
  req_t             head;

  state_t               state, phase, cur_phase;
  req_t                 req;
  logic                 req_bad, head_bad, issuing, win_last;
  logic [CNT_W-1:0]     cnt;
  logic [VAL_WIDTH-1:0] sample, debit_bal;

  assign in_ready   = (fifo_count != FIFO_FULL);
  assign fifo_empty = (fifo_count == '0);
  assign push       = in_valid && in_ready;
  assign head       = fifo_mem[rd_ptr];
  assign busy       = (state != IDLE) || !fifo_empty;
  assign win_last   = (cnt == CNT_LAST);

  // NOTE: payload storage has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= '{op: in_op, src: in_src_key, dst: in_dst_key, amount: in_amount};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    head_bad  = (head.op == OP_ILLEGAL) || (head.src == '0) ||
                ((head.op == OP_TRANSFER) && (head.dst == '0));
    pop       = !fifo_empty && ((state == IDLE) || ((state == RESP) && out_ready));
    issuing   = ((state == POP) && !req_bad) || (state == CHECK) || (state == DEBIT) ||
                (state == CREDIT) || (state == INSERT);
    cur_phase = state;
    if (state == POP) cur_phase = (req.op == OP_INSERT) ? INSERT : CHECK;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      phase             <= IDLE;
      req               <= '0;
      req_bad           <= 1'b0;
      cnt               <= '0;
      sample            <= '0;
      debit_bal         <= '0;
      kv_key            <= '0;
      kv_value          <= '0;
      kv_signal         <= SIG_SEARCH;
      kv_transact_value <= '0;
      kv_transact_kind  <= 1'b0;
      out_valid         <= 1'b0;
      out_status        <= STAT_OK;
      out_src_balance   <= '0;
      out_dst_balance   <= '0;
    end else begin
      // A store window ends by sampling the result and dropping into GAP with an idle bus.
      if (issuing) begin
        if (win_last) begin
          state             <= GAP;
          phase             <= cur_phase;
          sample            <= kv_updated_value;
          cnt               <= '0;
          kv_key            <= '0;
          kv_value          <= '0;
          kv_signal         <= SIG_SEARCH;
          kv_transact_value <= '0;
          kv_transact_kind  <= 1'b0;
        end else begin
          state <= cur_phase;
          cnt   <= cnt + CNT_W'(1);
        end
      end

      case (state)
        POP: if (req_bad) begin
          state           <= RESP;
          out_valid       <= 1'b1;
          out_status      <= STAT_BAD;
          out_src_balance <= '0;
          out_dst_balance <= '0;
        end
        GAP: case (phase)
          CHECK: begin
            if (req.op != OP_TRANSFER || req.src == req.dst || sample < req.amount) begin
              state           <= RESP;
              out_valid       <= 1'b1;
              out_src_balance <= sample;
              out_status      <= (req.op == OP_TRANSFER && req.src != req.dst) ? STAT_INSUF : STAT_OK;
              out_dst_balance <= (req.op == OP_TRANSFER && req.src == req.dst) ? sample : '0;
            end else begin
              state             <= DEBIT;
              kv_key            <= req.src;
              kv_signal         <= SIG_TRANSACT;
              kv_transact_value <= req.amount;
              kv_transact_kind  <= 1'b0;
            end
          end
          DEBIT: begin
            state             <= CREDIT;
            debit_bal         <= sample;
            kv_key            <= req.dst;
            kv_signal         <= SIG_TRANSACT;
            kv_transact_value <= req.amount;
            kv_transact_kind  <= 1'b1;
          end
          CREDIT: begin
            state           <= RESP;
            out_valid       <= 1'b1;
            out_status      <= STAT_OK;
            out_src_balance <= debit_bal;
            out_dst_balance <= sample;
          end
          INSERT: begin
            state           <= RESP;
            out_valid       <= 1'b1;
            out_status      <= STAT_OK;
            out_src_balance <= sample;
            out_dst_balance <= '0;
          end
          default: state <= IDLE;
        endcase
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: ;
      endcase

      // Loading the head opens the first store window in POP, so POP counts as window cycle one.
      if (pop) begin
        state     <= POP;
        req       <= head;
        req_bad   <= head_bad;
        cnt       <= '0;
        kv_key    <= head_bad ? '0 : head.src;
        kv_signal <= (!head_bad && head.op == OP_INSERT) ? SIG_INSERT : SIG_SEARCH;
        kv_value  <= (!head_bad && head.op == OP_INSERT) ? head.amount : '0;
        kv_transact_value <= '0;
        kv_transact_kind  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kv_txn_sequencer.sv
// Directed bench for kv_txn_sequencer: a behavioural ledger store answers commands on
// key/signal changes; request vectors carry hand-computed results, latencies and command counts.
module tb_kv_txn_sequencer;

  localparam int S  = 12;
  localparam int KW = 32;
  localparam int VW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = '0;
  logic [KW-1:0] in_src_key = '0;
  logic [KW-1:0] in_dst_key = '0;
  logic [VW-1:0] in_amount = '0;
  logic [KW-1:0] kv_key;
  logic [VW-1:0] kv_value;
  logic [1:0]    kv_signal;
  logic [VW-1:0] kv_transact_value;
  logic          kv_transact_kind;
  logic [VW-1:0] kv_updated_value = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_status;
  logic [VW-1:0] out_src_balance;
  logic [VW-1:0] out_dst_balance;
  logic          busy;

  always #5 clock = ~clock;

  kv_txn_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(S), .KEY_WIDTH(KW), .VAL_WIDTH(VW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src_key(in_src_key), .in_dst_key(in_dst_key), .in_amount(in_amount),
    .kv_key(kv_key), .kv_value(kv_value), .kv_signal(kv_signal),
    .kv_transact_value(kv_transact_value), .kv_transact_kind(kv_transact_kind),
    .kv_updated_value(kv_updated_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_status(out_status),
    .out_src_balance(out_src_balance), .out_dst_balance(out_dst_balance), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural store: executes a command once per key/signal change and holds its result.
  typedef struct {
    logic [1:0]    sig;
    logic          kind;
    logic [KW-1:0] key;
    logic [VW-1:0] val;
  } cmd_t;

  logic [VW-1:0] bal [logic [KW-1:0]];
  logic [KW-1:0] prev_key = '0;
  logic [1:0]    prev_sig = '0;
  logic [VW-1:0] cur_bal;
  cmd_t          cmd_q [$];
  cmd_t          cmd_new;
  int            run_len = 0;
  int            win_err = 0;

  always @(negedge clock) begin
    if (kv_key != '0 && (kv_key != prev_key || kv_signal != prev_sig)) begin
      if (prev_key != '0) win_err++;
      cur_bal       = bal.exists(kv_key) ? bal[kv_key] : '0;
      cmd_new.sig   = kv_signal;
      cmd_new.kind  = kv_transact_kind;
      cmd_new.key   = kv_key;
      cmd_new.val   = (kv_signal == 2'd2) ? kv_transact_value : kv_value;
      cmd_q.push_back(cmd_new);
      case (kv_signal)
        2'd1: begin bal[kv_key] = kv_value; kv_updated_value = kv_value; end
        2'd2: begin
          cur_bal = kv_transact_kind ? cur_bal + kv_transact_value : cur_bal - kv_transact_value;
          bal[kv_key] = cur_bal;
          kv_updated_value = cur_bal;
        end
        default: kv_updated_value = cur_bal;
      endcase
      run_len = 1;
    end else if (kv_key != '0) begin
      run_len++;
    end else if (prev_key != '0 && run_len != S) begin
      win_err++;
    end
    if (kv_key == '0 && kv_signal != 2'd0) win_err++;
    prev_key = kv_key;
    prev_sig = kv_signal;
  end

  typedef struct packed {
    logic [1:0]    st;
    logic [VW-1:0] sb;
    logic [VW-1:0] db;
  } res_t;

  res_t res_q [$];

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready)
      res_q.push_back('{st: out_status, sb: out_src_balance, db: out_dst_balance});
  end

  typedef struct {
    logic [1:0]    op;
    logic [KW-1:0] src;
    logic [KW-1:0] dst;
    logic [VW-1:0] amt;
    logic [1:0]    st;
    logic [VW-1:0] sb;
    logic [VW-1:0] db;
    int            lat;
    int            cmds;
  } vec_t;

  task automatic send(input logic [1:0] op, input logic [KW-1:0] s, input logic [KW-1:0] d,
                      input logic [VW-1:0] a);
    int g = 0;
    @(negedge clock);
    in_valid = 1'b1; in_op = op; in_src_key = s; in_dst_key = d; in_amount = a;
    while (!in_ready && g < 500) begin
      @(negedge clock);
      g++;
    end
    check("in_ready at send", in_ready, 1'b1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 500) begin
      @(posedge clock);
      #1 cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    cmd_q.delete();
    send(v.op, v.src, v.dst, v.amt);
    wait_valid(cyc);
    check({tag, " latency"}, cyc, v.lat);
    check({tag, " status"}, out_status, v.st);
    check({tag, " src_balance"}, out_src_balance, v.sb);
    check({tag, " dst_balance"}, out_dst_balance, v.db);
    check({tag, " store commands"}, cmd_q.size(), v.cmds);
    check({tag, " window shape"}, win_err, 0);
    if (cmd_q.size() == v.cmds && v.cmds > 0) begin
      check({tag, " cmd0 signal"}, cmd_q[0].sig, (v.op == 2'd1) ? 2'd1 : 2'd0);
      check({tag, " cmd0 key"}, cmd_q[0].key, v.src);
      if (v.op == 2'd1) check({tag, " cmd0 value"}, cmd_q[0].val, v.amt);
    end
    if (cmd_q.size() == 3 && v.cmds == 3) begin
      check({tag, " debit"}, {cmd_q[1].sig, cmd_q[1].kind, cmd_q[1].key, cmd_q[1].val},
            {2'd2, 1'b0, v.src, v.amt});
      check({tag, " credit"}, {cmd_q[2].sig, cmd_q[2].kind, cmd_q[2].key, cmd_q[2].val},
            {2'd2, 1'b1, v.dst, v.amt});
    end
    repeat (3) @(posedge clock);
    #1;
    check({tag, " held valid"}, out_valid, 1'b1);
    check({tag, " held src"}, out_src_balance, v.sb);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check({tag, " valid drop"}, out_valid, 1'b0);
    check({tag, " idle"}, busy, 1'b0);
  endtask

  localparam int NV = 16;
  vec_t vecs [NV];
  vec_t blk_v [6];

  initial begin
    int g;
    int cyc;
    // op, src, dst, amount, status, src_bal, dst_bal, latency, store commands
    vecs[0]  = '{2'd0, 32'h11, 32'h00, 32'd0,   2'd0, 32'd100, 32'd0,   14, 1};
    vecs[1]  = '{2'd2, 32'h11, 32'h22, 32'd30,  2'd0, 32'd70,  32'd80,  40, 3};
    vecs[2]  = '{2'd2, 32'h11, 32'h22, 32'd200, 2'd1, 32'd70,  32'd0,   14, 1};
    vecs[3]  = '{2'd0, 32'h11, 32'h00, 32'd0,   2'd0, 32'd70,  32'd0,   14, 1};
    vecs[4]  = '{2'd0, 32'h22, 32'h00, 32'd0,   2'd0, 32'd80,  32'd0,   14, 1};
    vecs[5]  = '{2'd3, 32'h11, 32'h22, 32'd5,   2'd2, 32'd0,   32'd0,   2,  0};
    vecs[6]  = '{2'd1, 32'h00, 32'h00, 32'd5,   2'd2, 32'd0,   32'd0,   2,  0};
    vecs[7]  = '{2'd2, 32'h11, 32'h11, 32'd10,  2'd0, 32'd70,  32'd70,  14, 1};
    vecs[8]  = '{2'd1, 32'h33, 32'h00, 32'd500, 2'd0, 32'd500, 32'd0,   14, 1};
    vecs[9]  = '{2'd2, 32'h33, 32'h22, 32'd0,   2'd0, 32'd500, 32'd80,  40, 3};
    vecs[10] = '{2'd2, 32'h22, 32'h11, 32'd80,  2'd0, 32'd0,   32'd150, 40, 3};
    vecs[11] = '{2'd2, 32'h22, 32'h11, 32'd1,   2'd1, 32'd0,   32'd0,   14, 1};
    vecs[12] = '{2'd2, 32'h11, 32'h00, 32'd5,   2'd2, 32'd0,   32'd0,   2,  0};
    vecs[13] = '{2'd0, 32'h11, 32'h00, 32'd0,   2'd0, 32'd150, 32'd0,   14, 1};
    vecs[14] = '{2'd0, 32'h11, 32'h00, 32'd0,   2'd0, 32'd150, 32'd0,   14, 1};
    vecs[15] = '{2'd0, 32'h44, 32'h00, 32'd0,   2'd0, 32'd0,   32'd0,   14, 1};

    bal[32'h11] = 32'd100;
    bal[32'h22] = 32'd50;

    #2 reset_n = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset kv bus", {kv_key, kv_value, kv_signal, kv_transact_value, kv_transact_kind}, '0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out fields", {out_status, out_src_balance, out_dst_balance}, '0);
    check("reset busy", busy, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-pressure: one result stalls in RESP while four more requests fill the FIFO.
    res_q.delete();
    send(2'd0, 32'h11, 32'h0, 32'd0);
    wait_valid(cyc);
    check("blocker latency", cyc, 14);
    send(2'd0, 32'h22, 32'h0, 32'd0);
    send(2'd0, 32'h33, 32'h0, 32'd0);
    send(2'd0, 32'h11, 32'h0, 32'd0);
    send(2'd0, 32'h22, 32'h0, 32'd0);
    @(negedge clock);
    check("in_ready when full", in_ready, 1'b0);
    check("busy when full", busy, 1'b1);
    check("stalled valid", out_valid, 1'b1);
    @(posedge clock);
    #1 out_ready = 1'b1;
    send(2'd0, 32'h33, 32'h0, 32'd0);
    g = 0;
    while (res_q.size() < 6 && g < 1000) begin
      @(posedge clock);
      #1 g++;
    end
    out_ready = 1'b0;
    check("stall result count", res_q.size(), 6);
    blk_v[0].sb = 32'd150; blk_v[1].sb = 32'd0;   blk_v[2].sb = 32'd500;
    blk_v[3].sb = 32'd150; blk_v[4].sb = 32'd0;   blk_v[5].sb = 32'd500;
    for (int i = 0; i < 6 && i < res_q.size(); i++)
      check($sformatf("stall result %0d", i), res_q[i], {2'd0, blk_v[i].sb, 32'd0});
    repeat (2) @(negedge clock);
    check("idle after stall", busy, 1'b0);

    // Reset during DEBIT: the debit sticks, the credit never happens.
    send(2'd2, 32'h33, 32'h11, 32'd100);
    g = 0;
    while (kv_signal != 2'd2 && g < 200) begin
      @(negedge clock);
      g++;
    end
    check("debit reached", {kv_signal, kv_transact_kind}, {2'd2, 1'b0});
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async reset kv bus", {kv_key, kv_value, kv_signal, kv_transact_value, kv_transact_kind}, '0);
    check("async reset out", {out_valid, out_status, out_src_balance, out_dst_balance}, '0);
    check("async reset busy", busy, 1'b0);
    check("async reset in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    win_err = 0;
    run_vec('{2'd0, 32'h33, 32'h00, 32'd0, 2'd0, 32'd400, 32'd0, 14, 1}, "post-reset src");
    run_vec('{2'd0, 32'h11, 32'h00, 32'd0, 2'd0, 32'd150, 32'd0, 14, 1}, "post-reset dst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
